// File: rtl/rv32i_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_wb_arbiter_pkg
// Shared definitions for the write-back arbiter slice:
//   occ_e        - occupancy of the 2-entry MDU result buffer
//   wb_req_t     - a register-file write request {we, rd, data}
//   DEFAULT_MAX_WAIT / DEFAULT_WIDTH - parameter defaults
//   rd_onehot()  - rd index to a 32-bit one-hot register mask
// ---------------------------------------------------------------------------
package rv32i_wb_arbiter_pkg;

  localparam int DEFAULT_WIDTH    = 32;
  localparam int DEFAULT_MAX_WAIT = 4;
  localparam int RD_W             = 5;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  typedef struct packed {
    logic                     we;
    logic [RD_W-1:0]          rd;
    logic [DEFAULT_WIDTH-1:0] data;
  } wb_req_t;

  function automatic logic [31:0] rd_onehot(input logic [RD_W-1:0] rd);
    return 32'd1 << rd;
  endfunction

endpackage

// File: rtl/rv32i_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// rv32i_wb_arbiter_if
// Bundles the write-back stage request, the MDU result handshake and the
// register-file write port of the arbiter.
//   slave  modport - used by the arbiter (takes i_*, drives o_*)
//   master modport - used by the surrounding core / testbench
// ---------------------------------------------------------------------------
interface rv32i_wb_arbiter_if #(
  parameter int WIDTH = 32
);
  // write-back stage request (already muxed ALU/MEM/PC)
  logic             i_pipe_we;
  logic [4:0]       i_pipe_rd;
  logic [WIDTH-1:0] i_pipe_data;
  // multi-cycle MUL/DIV result
  logic             i_mdu_valid;
  logic [4:0]       i_mdu_rd;
  logic [WIDTH-1:0] i_mdu_data;
  logic             o_mdu_ready;
  // register-file write port
  logic             o_rf_we;
  logic [4:0]       o_rf_rd;
  logic [WIDTH-1:0] o_rf_data;
  // pipeline control / hazard information
  logic             o_stall_pipe;
  logic [31:0]      o_pending_mask;

  modport slave (
    input  i_pipe_we, i_pipe_rd, i_pipe_data,
    input  i_mdu_valid, i_mdu_rd, i_mdu_data,
    output o_mdu_ready,
    output o_rf_we, o_rf_rd, o_rf_data,
    output o_stall_pipe, o_pending_mask
  );

  modport master (
    output i_pipe_we, i_pipe_rd, i_pipe_data,
    output i_mdu_valid, i_mdu_rd, i_mdu_data,
    input  o_mdu_ready,
    input  o_rf_we, o_rf_rd, o_rf_data,
    input  o_stall_pipe, o_pending_mask
  );

endinterface

// File: rtl/rv32i_wb_fifo2.sv
// ---------------------------------------------------------------------------
// rv32i_wb_fifo2
// Two-entry in-order buffer for MDU results. Slot 0 is always the head;
// a pop shifts slot 1 down, a push fills the first free slot after the pop,
// so a simultaneous pop and push keeps the occupancy unchanged.
// Ports:
//   clk, srst                 - clock, synchronous active-high reset
//   push, push_rd, push_data  - enqueue (caller never pushes when FULL)
//   pop                       - dequeue the head (ignored when empty)
//   occ                       - EMPTY / ONE / FULL
//   head_valid/rd/data        - current head entry
//   entry_valid, entry_rd     - per-slot valid and rd for hazard tracking
// ---------------------------------------------------------------------------
module rv32i_wb_fifo2
  import rv32i_wb_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [4:0]       push_rd,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output occ_e             occ,
  output logic             head_valid,
  output logic [4:0]       head_rd,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       entry_valid,
  output logic [4:0]       entry_rd [2]
);

  logic [1:0]       valid_reg, valid_next;
  logic [4:0]       rd_reg    [2];
  logic [4:0]       rd_next   [2];
  logic [WIDTH-1:0] data_reg  [2];
  logic [WIDTH-1:0] data_next [2];

  always_comb begin
    valid_next = valid_reg;
    rd_next    = rd_reg;
    data_next  = data_reg;
    if (pop && valid_reg[0]) begin
      valid_next   = {1'b0, valid_reg[1]};
      rd_next[0]   = rd_reg[1];
      data_next[0] = data_reg[1];
    end
    if (push) begin
      if (!valid_next[0]) begin
        valid_next[0] = 1'b1;
        rd_next[0]    = push_rd;
        data_next[0]  = push_data;
      end else begin
        valid_next[1] = 1'b1;
        rd_next[1]    = push_rd;
        data_next[1]  = push_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      valid_reg <= 2'b00;
    end else begin
      valid_reg <= valid_next;
    end
  end

  // Payload needs no reset: it is only observed through a set valid bit.
  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      rd_reg[gi]   <= rd_next[gi];
      data_reg[gi] <= data_next[gi];
    end
    assign entry_rd[gi] = rd_reg[gi];
  end

  // Valid bits are kept contiguous from slot 0, so 2'b10 cannot occur.
  always_comb begin
    case (valid_reg)
      2'b11:   occ = OCC_FULL;
      2'b01:   occ = OCC_ONE;
      default: occ = OCC_EMPTY;
    endcase
  end

  assign head_valid  = valid_reg[0];
  assign head_rd     = rd_reg[0];
  assign head_data   = data_reg[0];
  assign entry_valid = valid_reg;

endmodule

// File: rtl/rv32i_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rv32i_wb_arbiter
// Shares the single register-file write port between the write-back stage
// and the multi-cycle MUL/DIV unit. MDU results are buffered (2 entries,
// in order) and drained when the pipe does not write. A head that loses
// arbitration MAX_WAIT times forces a one-cycle pipe stall in which it is
// written.
// Ports:
//   i_clk, i_rst  - clock, synchronous active-high reset
//   bus (slave)   - pipe request, MDU handshake, register-file write port,
//                   o_stall_pipe (registered) and o_pending_mask
// Configuration macro:
//   WB_ARB_BYPASS_EN - when defined, an MDU result arriving while the buffer
//                      is empty and the pipe does not write goes straight to
//                      the register file in the same cycle.
// ---------------------------------------------------------------------------
module rv32i_wb_arbiter
  import rv32i_wb_arbiter_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input logic               i_clk,
  input logic               i_rst,
  rv32i_wb_arbiter_if.slave bus
);

  localparam int              AGE_W     = $clog2(MAX_WAIT + 1) + 1;
  localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(MAX_WAIT);

  occ_e             occ;
  logic             head_valid;
  logic [4:0]       head_rd;
  logic [WIDTH-1:0] head_data;
  logic [1:0]       entry_valid;
  logic [4:0]       entry_rd [2];

  logic             mdu_ready;
  logic             mdu_fire;
  logic             mdu_keep;
  logic             pipe_req;
  logic             grant_head;
  logic             grant_pipe;
  logic             grant_mdu;
  logic             fifo_push;
  logic             head_change;

  logic             stall_reg, stall_next;
  logic [AGE_W-1:0] age_reg, age_next;

  assign mdu_ready = (occ != OCC_FULL);
  // A handshake during reset is discarded along with the buffer contents.
  assign mdu_fire  = bus.i_mdu_valid && mdu_ready && !i_rst;
  // rd=0 results are consumed but never stored or written.
  assign mdu_keep  = mdu_fire && (bus.i_mdu_rd != 5'd0);
  // A pipe write to x0 is no write at all and does not block the buffer.
  assign pipe_req  = bus.i_pipe_we && (bus.i_pipe_rd != 5'd0);

  // Grant: forced head > pipe > buffered head > (optional) direct MDU.
  // Nothing is granted while in reset so discarded entries never commit.
  always_comb begin
    grant_head = 1'b0;
    grant_pipe = 1'b0;
    grant_mdu  = 1'b0;
    if (!i_rst) begin
      if (stall_reg) begin
        grant_head = head_valid;
      end else if (pipe_req) begin
        grant_pipe = 1'b1;
      end else if (head_valid) begin
        grant_head = 1'b1;
`ifdef WB_ARB_BYPASS_EN
      end else if (mdu_keep) begin
        // Reaching here means the buffer is empty and the pipe is idle.
        grant_mdu = 1'b1;
`endif
      end
    end
  end

  always_comb begin
    bus.o_rf_we   = grant_head || grant_pipe || grant_mdu;
    bus.o_rf_rd   = 5'd0;
    bus.o_rf_data = '0;
    if (grant_pipe) begin
      bus.o_rf_rd   = bus.i_pipe_rd;
      bus.o_rf_data = bus.i_pipe_data;
    end else if (grant_head) begin
      bus.o_rf_rd   = head_rd;
      bus.o_rf_data = head_data;
    end else if (grant_mdu) begin
      bus.o_rf_rd   = bus.i_mdu_rd;
      bus.o_rf_data = bus.i_mdu_data;
    end
  end

  assign fifo_push = mdu_keep && !grant_mdu;

  rv32i_wb_fifo2 #(
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk         (i_clk),
    .srst        (i_rst),
    .push        (fifo_push),
    .push_rd     (bus.i_mdu_rd),
    .push_data   (bus.i_mdu_data),
    .pop         (grant_head),
    .occ         (occ),
    .head_valid  (head_valid),
    .head_rd     (head_rd),
    .head_data   (head_data),
    .entry_valid (entry_valid),
    .entry_rd    (entry_rd)
  );

  // The head changes when it is written or when a push lands in an empty
  // buffer; a push behind an existing head leaves its age alone.
  assign head_change = grant_head || (fifo_push && !head_valid);

  always_comb begin
    age_next   = age_reg;
    stall_next = 1'b0;
    if (head_change) begin
      age_next = '0;
    end else if (head_valid && !grant_head) begin
      age_next = age_reg + AGE_W'(1);
      // The stall cycle always writes the head, so the age restarts and
      // two stall cycles can never be adjacent.
      stall_next = !stall_reg && (age_next >= AGE_LIMIT);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      age_reg   <= '0;
      stall_reg <= 1'b0;
    end else begin
      age_reg   <= age_next;
      stall_reg <= stall_next;
    end
  end

  assign bus.o_mdu_ready  = mdu_ready;
  assign bus.o_stall_pipe = stall_reg;

  // Hazard mask from valid entries only; stale payloads never show up.
  logic [31:0] entry_mask [2];
  for (genvar gi = 0; gi < 2; gi++) begin : g_mask
    assign entry_mask[gi] = entry_valid[gi] ? rd_onehot(entry_rd[gi]) : 32'd0;
  end
  assign bus.o_pending_mask = entry_mask[0] | entry_mask[1];

endmodule

// File: tb/tb_rv32i_wb_arbiter.sv
`timescale 1ns/1ps
module tb_rv32i_wb_arbiter;
  import rv32i_wb_arbiter_pkg::*;

  localparam int WIDTH    = 32;
  localparam int MAX_WAIT = 4;
`ifdef WB_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv32i_wb_arbiter_if #(.WIDTH(WIDTH)) bus ();

  rv32i_wb_arbiter #(
    .WIDTH    (WIDTH),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Reference model: ordered queue of buffered results, number of cycles
  // the current head has been passed over, and the forced-write flag.
  wb_req_t q[$];
  int      lost;
  bit      m_stall;
  bit      last_accept;
  int      checks;
  int      errors;

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = 32'd0;
    foreach (q[i]) m |= 32'd1 << q[i].rd;
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare every output with the model,
  // then advance the model by that cycle.
  task automatic step(input logic r, input logic pwe, input logic [4:0] prd,
                      input logic [31:0] pdata, input logic mv,
                      input logic [4:0] mrd, input logic [31:0] mdata);
    logic        accept, bypass, pop, was_empty, changed;
    logic        exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data, exp_mask;
    wb_req_t     e;
    @(negedge clk);
    rst             = r;
    bus.i_pipe_we   = pwe;
    bus.i_pipe_rd   = prd;
    bus.i_pipe_data = pdata;
    bus.i_mdu_valid = mv;
    bus.i_mdu_rd    = mrd;
    bus.i_mdu_data  = mdata;
    #1;
    exp_mask = model_mask();
    if (!r && pwe && prd != 5'd0) begin
      checks++;
      assert (exp_mask[prd] == 1'b0) else begin
        errors++;
        $error("FAIL hazard pipe rd=%0d observed pending=0x%08h expected clear", prd, exp_mask);
      end
    end
    accept   = mv && (q.size() < 2) && !r;
    exp_we   = 1'b0;
    exp_rd   = 5'd0;
    exp_data = 32'd0;
    pop      = 1'b0;
    bypass   = 1'b0;
    if (!r) begin
      if (q.size() > 0 && (m_stall || !(pwe && prd != 5'd0))) begin
        pop = 1'b1; exp_we = 1'b1; exp_rd = q[0].rd; exp_data = q[0].data;
      end else if (pwe && prd != 5'd0) begin
        exp_we = 1'b1; exp_rd = prd; exp_data = pdata;
      end else if (BYP && accept && mrd != 5'd0) begin
        bypass = 1'b1; exp_we = 1'b1; exp_rd = mrd; exp_data = mdata;
      end
    end
    chk("rf_we",     32'(bus.o_rf_we),      32'(exp_we));
    chk("rf_rd",     32'(bus.o_rf_rd),      32'(exp_rd));
    if (exp_we) chk("rf_data", bus.o_rf_data, exp_data);
    chk("mdu_ready", 32'(bus.o_mdu_ready),  32'(q.size() < 2));
    chk("stall",     32'(bus.o_stall_pipe), 32'(m_stall));
    chk("pending",   bus.o_pending_mask,    exp_mask);
    if (bus.o_rf_we)
      $display("t=%0t wb write rd=%0d data=0x%08h stall=%0b", $time, bus.o_rf_rd, bus.o_rf_data, bus.o_stall_pipe);
    last_accept = accept;
    if (r) begin
      q.delete();
      lost    = 0;
      m_stall = 1'b0;
    end else begin
      was_empty = (q.size() == 0);
      if (pop) void'(q.pop_front());
      if (accept && mrd != 5'd0 && !bypass) begin
        e.we = 1'b1; e.rd = mrd; e.data = mdata;
        q.push_back(e);
      end
      changed = pop || (was_empty && q.size() > 0);
      if (changed) lost = 0;
      else if (q.size() > 0) lost++;
      m_stall = (q.size() > 0) && (lost == MAX_WAIT);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  logic        r_v, pwe_v, mv_v, pipe_hold, mdu_hold;
  logic [4:0]  prd_v, mrd_v;
  logic [31:0] pdata_v, mdata_v, pm;

  initial begin
    checks = 0; errors = 0; lost = 0; m_stall = 1'b0; last_accept = 1'b0;
    q.delete();
    rst = 1'b1;
    bus.i_pipe_we = 1'b0; bus.i_pipe_rd = 5'd0; bus.i_pipe_data = 32'd0;
    bus.i_mdu_valid = 1'b0; bus.i_mdu_rd = 5'd0; bus.i_mdu_data = 32'd0;
    repeat (2) @(negedge clk);

    // Reset state
    idle();
    chk("rst_ready",   32'(bus.o_mdu_ready),  32'd1);
    chk("rst_stall",   32'(bus.o_stall_pipe), 32'd0);
    chk("rst_pending", bus.o_pending_mask,    32'd0);

    // Single MDU result, idle pipe
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h0000_00AA);
    chk("r31_c0_we", 32'(bus.o_rf_we), 32'(BYP));
    idle();
    chk("r31_c1_we", 32'(bus.o_rf_we), 32'(!BYP));
    if (bus.o_rf_we) chk("r31_c1_data", bus.o_rf_data, 32'h0000_00AA);

    // Starved head forces exactly one stall after MAX_WAIT losses
    step(1'b0, 1'b1, 5'd10, 32'h100, 1'b1, 5'd7, 32'h77);
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 1'b1, 5'(10 + k), 32'(256 + k), 1'b0, 5'd0, 32'd0);
      chk("r32_nostall", 32'(bus.o_stall_pipe), 32'd0);
    end
    step(1'b0, 1'b1, 5'd15, 32'h15, 1'b0, 5'd0, 32'd0);
    chk("r32_stall", 32'(bus.o_stall_pipe), 32'd1);
    chk("r32_rd7",   32'(bus.o_rf_rd),      32'd7);
    step(1'b0, 1'b1, 5'd15, 32'h15, 1'b0, 5'd0, 32'd0);
    chk("r32_repres", 32'(bus.o_rf_rd),      32'd15);
    chk("r32_after",  32'(bus.o_stall_pipe), 32'd0);

    // Two buffered results fill the buffer and drain in order
    step(1'b0, 1'b1, 5'd11, 32'h1, 1'b1, 5'd3, 32'h33);
    step(1'b0, 1'b1, 5'd12, 32'h2, 1'b1, 5'd4, 32'h44);
    step(1'b0, 1'b1, 5'd13, 32'h3, 1'b0, 5'd0, 32'd0);
    chk("r33_ready", 32'(bus.o_mdu_ready), 32'd0);
    chk("r33_mask",  bus.o_pending_mask,   32'h18);
    idle();
    chk("r33_first",  32'(bus.o_rf_rd), 32'd3);
    idle();
    chk("r33_second", 32'(bus.o_rf_rd), 32'd4);

    // rd=0 result is dropped
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    chk("r34_we0", 32'(bus.o_rf_we), 32'd0);
    idle();
    chk("r34_we1",  32'(bus.o_rf_we),     32'd0);
    chk("r34_mask", bus.o_pending_mask,   32'd0);

    // Pipe write to x0 does not block the buffered head
    step(1'b0, 1'b1, 5'd11, 32'h1, 1'b1, 5'd9, 32'h99);
    step(1'b0, 1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
    chk("r36_we", 32'(bus.o_rf_we), 32'd1);
    chk("r36_rd", 32'(bus.o_rf_rd), 32'd9);

    // Reset with a full buffer discards it
    step(1'b0, 1'b1, 5'd11, 32'h1, 1'b1, 5'd20, 32'h20);
    step(1'b0, 1'b1, 5'd12, 32'h2, 1'b1, 5'd21, 32'h21);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("r35_rstwe", 32'(bus.o_rf_we), 32'd0);
    idle();
    chk("r35_mask",  bus.o_pending_mask,   32'd0);
    chk("r35_ready", 32'(bus.o_mdu_ready), 32'd1);
    chk("r35_we",    32'(bus.o_rf_we),     32'd0);

    // MDU handshake during reset is ignored
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h66);
    idle();
    chk("r25_we",   32'(bus.o_rf_we),   32'd0);
    chk("r25_mask", bus.o_pending_mask, 32'd0);

    // Randomised traffic against the model
    pwe_v = 1'b0; prd_v = 5'd0; pdata_v = 32'd0;
    mv_v = 1'b0; mrd_v = 5'd0; mdata_v = 32'd0;
    last_accept = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      r_v       = ($urandom_range(0, 249) == 0);
      pipe_hold = m_stall;
      mdu_hold  = mv_v && !last_accept;
      if (!mdu_hold) begin
        mv_v = ($urandom_range(0, 2) == 0);
        do begin
          mrd_v = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        end while (pipe_hold && mrd_v != 5'd0 && mrd_v == prd_v);
        mdata_v = $urandom;
      end
      if (!pipe_hold) begin
        pm    = model_mask();
        pwe_v = ($urandom_range(0, 3) != 0);
        do begin
          prd_v = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        end while (prd_v != 5'd0 && (pm[prd_v] || prd_v == mrd_v));
        pdata_v = $urandom;
      end
      step(r_v, pwe_v, prd_v, pdata_v, mv_v, mrd_v, mdata_v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_wb_arbiter.md
RV32I_WB_ARBITER -- requirements
Module: rv32i_wb_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, register data width.
REQ-002 SHALL have parameter MAX_WAIT, default 4, max cycles a buffered MDU result may lose arbitration before a forced stall.
REQ-003 SHALL have port i_clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have ports i_pipe_we (input, 1), i_pipe_rd (input, 5) and i_pipe_data (input, WIDTH): the write-back stage request, already muxed from ALU/MEM/PC.
REQ-006 SHALL have ports i_mdu_valid (input, 1), i_mdu_rd (input, 5) and i_mdu_data (input, WIDTH): the multi-cycle MUL/DIV result.
REQ-007 SHALL have port o_mdu_ready, output, 1: the MDU result is accepted when i_mdu_valid and o_mdu_ready are both high.
REQ-008 SHALL have ports o_rf_we (output, 1), o_rf_rd (output, 5) and o_rf_data (output, WIDTH): the single register-file write port.
REQ-009 SHALL have port o_stall_pipe, output, 1, registered: the write-back stage holds and re-presents its request next cycle.
REQ-010 SHALL have port o_pending_mask, output, 32: bit r is set while any buffered entry targets rd r.

Function
REQ-011 SHALL hold MDU results in a 2-entry in-order buffer; occupancy states EMPTY, ONE, FULL.
REQ-012 o_mdu_ready SHALL equal (occupancy != FULL), combinational from state.
REQ-013 An accepted MDU result with rd=0 SHALL be dropped: not buffered and never written.
REQ-014 Grant priority per cycle SHALL be:
 - (a) o_stall_pipe high -> buffer head; the pipe request is ignored.
 - (b) i_pipe_we && i_pipe_rd!=0 -> pipe.
 - (c) buffer non-empty -> head.
 - (d) otherwise no write.
REQ-015 The write port SHALL be combinational from the grant; a pipe write has zero latency.
REQ-016 A buffered result SHALL reach o_rf_* no earlier than the cycle after acceptance.
REQ-017 Simultaneous pop and push SHALL keep occupancy unchanged; push when FULL cannot occur.
REQ-018 An age counter SHALL track the head:
 - It clears on every head change.
 - It increments each cycle the head exists and is not granted.
 - When it reaches MAX_WAIT, o_stall_pipe SHALL be high for exactly the next cycle, and that cycle SHALL grant the head.
REQ-019 o_stall_pipe SHALL never be high for two consecutive cycles.
REQ-020 o_pending_mask SHALL be derived from valid buffer entries only.
REQ-021 A pipe request to an rd set in o_pending_mask is illegal; the hazard unit prevents it; the bench asserts it never occurs.
REQ-022 o_rf_we SHALL never be high with o_rf_rd=0.

Reset
REQ-023 On i_rst high at a clock edge:
 - Occupancy SHALL become EMPTY and the age counter 0.
 - o_stall_pipe, o_rf_we and o_pending_mask SHALL become 0.
 - o_mdu_ready SHALL become 1.
REQ-024 Reset mid-operation SHALL discard buffered entries without writing them.
REQ-025 An MDU handshake in the reset cycle SHALL be ignored.

Configuration
REQ-026 Macro WB_ARB_BYPASS_EN defined: with the buffer EMPTY, no pipe write and an MDU handshake in the same cycle, the result SHALL be written directly in that cycle and not buffered.
REQ-027 WB_ARB_BYPASS_EN undefined: every MDU result SHALL pass through the buffer (minimum 1-cycle latency).

Structure
REQ-028 The shared decoder header/package SHALL hold the occupancy-state enum, the write-back request struct {we, rd, data} and the default MAX_WAIT.
REQ-029 The buffer SHALL be a sub-module rv32i_wb_fifo2 (2-entry FIFO with per-entry rd output).
REQ-030 Arbitration and the age counter SHALL stay in the top level.

Verification
REQ-031 Idle pipe; MDU result rd=5, data=0x0000_00AA accepted at cycle 0 -> o_rf_we=1, rd=5, data=0xAA at cycle 1 (bypass off) or cycle 0 (bypass on).
REQ-032 Pipe writes every cycle; one MDU result rd=7 buffered, MAX_WAIT=4 -> o_stall_pipe=1 for exactly one cycle 4 cycles after buffering, rd=7 written that cycle, pipe re-presented next.
REQ-033 Two MDU results rd=3, rd=4 with pipe busy -> o_mdu_ready=0, o_pending_mask=0x18; results written in order 3 then 4.
REQ-034 MDU result rd=0 with data 0xFFFF_FFFF -> no register write; occupancy unchanged.
REQ-035 Buffer FULL, i_rst asserted one cycle -> next cycle o_pending_mask=0, o_mdu_ready=1, no register write of the discarded entries.
REQ-036 Pipe rd=0 with we=1 and buffer head rd=9 -> head written that cycle (the pipe request counts as no write).
